// File: rtl/icache_req_stage.sv
`default_nettype none
// ============================================================================
// Module      : icache_req_stage
// Description : Instruction-fetch request stage in front of the ICache. It
//               holds each request until the cache accepts it, counts the
//               outstanding requests and squashes data for flushed requests.
//               Optional macro ICACHE_REQ_PERF_EN adds performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_req_stage #(
    parameter int ADDR_W   = 32,
    parameter int INDEX_W  = 7,
    parameter int OFFSET_W = 5,
    parameter int MAX_OUT  = 2,
    localparam int TAG_W   = ADDR_W - INDEX_W - OFFSET_W,
    localparam int CW      = $clog2(MAX_OUT + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                flush,
    input  logic [ADDR_W-1:0]   npc,
    input  logic                req_valid_in,
    input  logic                addr_ok,
    input  logic                data_ok,
    output logic                icache_valid_out,
    output logic [TAG_W-1:0]    icache_tag,
    output logic [INDEX_W-1:0]  icache_index,
    output logic [OFFSET_W-1:0] icache_offset,
    output logic                ins_valid,
    output logic [CW-1:0]       outstanding,
`ifdef ICACHE_REQ_PERF_EN
    output logic [31:0]         perf_req_cnt,
    output logic [31:0]         perf_squash_cnt,
`endif
    output logic                busy
);

    localparam logic [CW-1:0] c_max_out = CW'(MAX_OUT);

    logic              r_req;
    logic [ADDR_W-1:0] r_addr;
    logic [CW-1:0]     r_outstanding;
    logic [CW-1:0]     r_discard;

    logic              w_valid_out;
    logic              w_accept;
    logic              w_free;
    logic              w_live_data;
    logic [CW-1:0]     w_out_next;

    assign w_valid_out = r_req & (r_outstanding < c_max_out);
    assign w_accept    = w_valid_out & addr_ok;
    assign w_free      = ~r_req | w_accept;
    // data_ok with nothing outstanding is a protocol error and is ignored
    assign w_live_data = data_ok & (r_outstanding != '0);
    assign w_out_next  = r_outstanding + CW'(w_accept) - CW'(w_live_data);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req         <= 1'b0;
            r_addr        <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            if (flush) begin
                r_req <= 1'b0;
            end else if (!stall && w_free) begin
                r_req  <= req_valid_in;
                r_addr <= npc;
            end

            r_outstanding <= w_out_next;

            // Every request still in flight after a flush belongs to the dead stream
            if (flush) begin
                r_discard <= w_out_next;
            end else if (data_ok && (r_discard != '0)) begin
                r_discard <= r_discard - 1'b1;
            end
        end
    end

    assign icache_valid_out = w_valid_out;
    assign {icache_tag, icache_index, icache_offset} = r_addr;
    assign ins_valid   = w_live_data & (r_discard == '0);
    assign outstanding = r_outstanding;
    assign busy        = r_req | (r_outstanding != '0);

`ifdef ICACHE_REQ_PERF_EN
    logic [31:0] r_perf_req;
    logic [31:0] r_perf_squash;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_req    <= '0;
            r_perf_squash <= '0;
        end else begin
            if (w_accept) begin
                r_perf_req <= r_perf_req + 32'd1;
            end
            if (w_live_data && (r_discard != '0)) begin
                r_perf_squash <= r_perf_squash + 32'd1;
            end
        end
    end

    assign perf_req_cnt    = r_perf_req;
    assign perf_squash_cnt = r_perf_squash;
`endif

endmodule
`default_nettype wire

// File: tb/tb_icache_req_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_req_stage
// Description : Self-checking bench for icache_req_stage; directed scenarios
//               plus randomized traffic against an in-flight queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_req_stage;

    localparam int ADDR_W   = 32;
    localparam int INDEX_W  = 7;
    localparam int OFFSET_W = 5;
    localparam int MAX_OUT  = 2;
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int CW       = $clog2(MAX_OUT + 1);

    logic                clk = 1'b0;
    logic                rst;
    logic                stall;
    logic                flush;
    logic [ADDR_W-1:0]   npc;
    logic                req_valid_in;
    logic                addr_ok;
    logic                data_ok;
    logic                icache_valid_out;
    logic [TAG_W-1:0]    icache_tag;
    logic [INDEX_W-1:0]  icache_index;
    logic [OFFSET_W-1:0] icache_offset;
    logic                ins_valid;
    logic [CW-1:0]       outstanding;
    logic                busy;
`ifdef ICACHE_REQ_PERF_EN
    logic [31:0]         perf_req_cnt;
    logic [31:0]         perf_squash_cnt;
`endif

    int errors = 0;
    int checks = 0;

    icache_req_stage #(
        .ADDR_W   (ADDR_W),
        .INDEX_W  (INDEX_W),
        .OFFSET_W (OFFSET_W),
        .MAX_OUT  (MAX_OUT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .flush            (flush),
        .npc              (npc),
        .req_valid_in     (req_valid_in),
        .addr_ok          (addr_ok),
        .data_ok          (data_ok),
        .icache_valid_out (icache_valid_out),
        .icache_tag       (icache_tag),
        .icache_index     (icache_index),
        .icache_offset    (icache_offset),
        .ins_valid        (ins_valid),
        .outstanding      (outstanding),
`ifdef ICACHE_REQ_PERF_EN
        .perf_req_cnt     (perf_req_cnt),
        .perf_squash_cnt  (perf_squash_cnt),
`endif
        .busy             (busy)
    );

    always #5 clk = ~clk;

    // Reference model: a pending slot plus a queue of in-flight requests,
    // each tagged live (1) or killed by a flush (0).
    bit              m_req;
    bit [ADDR_W-1:0] m_addr;
    bit              m_q[$];
    int unsigned     m_perf_req;
    int unsigned     m_perf_sq;

    function automatic bit exp_vo();
        return m_req && (m_q.size() < MAX_OUT);
    endfunction

    function automatic bit exp_iv();
        return data_ok && (m_q.size() > 0) && m_q[0];
    endfunction

    task automatic model_tick();
        bit acc;
        bit dok;
        if (rst) begin
            m_req = 0;
            m_addr = '0;
            m_q.delete();
            m_perf_req = 0;
            m_perf_sq = 0;
        end else begin
            acc = exp_vo() && addr_ok;
            dok = data_ok && (m_q.size() > 0);
            if (dok) begin
                if (!m_q[0]) m_perf_sq++;
                void'(m_q.pop_front());
            end
            if (acc) begin
                m_q.push_back(1'b1);
                m_perf_req++;
            end
            if (flush) begin
                foreach (m_q[i]) m_q[i] = 1'b0;
                m_req = 0;
            end else if (!stall && (!m_req || acc)) begin
                m_req = req_valid_in;
                m_addr = npc;
            end
        end
    endtask

    task automatic cycle();
        model_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; stall = 0; flush = 0; npc = '0;
        req_valid_in = 0; addr_ok = 0; data_ok = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        cycle();
        cycle();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({icache_valid_out, icache_tag, icache_index, icache_offset, ins_valid, outstanding, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got vo=%0b addr=%h iv=%0b out=%0d busy=%0b required all zero",
                     icache_valid_out, {icache_tag, icache_index, icache_offset}, ins_valid, outstanding, busy);
        end
        data_ok = 1;
        #1;
        checks++;
        if (ins_valid !== 1'b0) begin
            errors++;
            $display("FAIL stray_data_ok_iv got=%0b required=0", ins_valid);
        end
        cycle();
        data_ok = 0;
        #1;
        checks++;
        if (outstanding !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stray_data_ok_sat got out=%0d busy=%0b required out=0 busy=0", outstanding, busy);
        end
    endtask

    task automatic test_first_fetch();
        do_reset();
        npc = 32'h1C00_0000; req_valid_in = 1; addr_ok = 1;
        cycle();
        #1;
        checks++;
        if (icache_valid_out !== 1'b1 || icache_tag !== 20'h1C000 || icache_index !== '0 || icache_offset !== '0) begin
            errors++;
            $display("FAIL first_fetch got vo=%0b tag=%h idx=%h off=%h required vo=1 tag=1c000 idx=0 off=0",
                     icache_valid_out, icache_tag, icache_index, icache_offset);
        end
        cycle();
        #1;
        checks++;
        if (outstanding !== CW'(1)) begin
            errors++;
            $display("FAIL first_accept_out got=%0d required=1", outstanding);
        end
    endtask

    task automatic test_hold_and_max_out();
        do_reset();
        npc = 32'h1C00_0000; req_valid_in = 1; addr_ok = 0;
        cycle();
        for (int k = 1; k <= 3; k++) begin
            npc = 32'h1C00_0000 + 32'(4 * k);
            addr_ok = (k == 3);
            #1;
            checks++;
            if ({icache_tag, icache_index, icache_offset} !== 32'h1C00_0000 || icache_valid_out !== 1'b1) begin
                errors++;
                $display("FAIL hold_addr k=%0d got addr=%h vo=%0b required addr=1c000000 vo=1",
                         k, {icache_tag, icache_index, icache_offset}, icache_valid_out);
            end
            cycle();
        end
        #1;
        checks++;
        if ({icache_tag, icache_index, icache_offset} !== 32'h1C00_000C || outstanding !== CW'(1)) begin
            errors++;
            $display("FAIL capture_after_accept got addr=%h out=%0d required addr=1c00000c out=1",
                     {icache_tag, icache_index, icache_offset}, outstanding);
        end
        cycle();
        #1;
        checks++;
        if (outstanding !== CW'(2) || icache_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL max_out got out=%0d vo=%0b required out=2 vo=0", outstanding, icache_valid_out);
        end
        data_ok = 1;
        #1;
        checks++;
        if (ins_valid !== 1'b1 || icache_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL max_out_data got iv=%0b vo=%0b required iv=1 vo=0", ins_valid, icache_valid_out);
        end
        cycle();
        data_ok = 0;
        #1;
        checks++;
        if (outstanding !== CW'(1) || icache_valid_out !== 1'b1) begin
            errors++;
            $display("FAIL max_out_release got out=%0d vo=%0b required out=1 vo=1", outstanding, icache_valid_out);
        end
    endtask

    task automatic test_flush_discard();
        int unsigned sq0;
        int unsigned rq0;
        // continues from the previous scenario: outstanding=1, request pending
        sq0 = m_perf_sq;
        rq0 = m_perf_req;
        addr_ok = 1;
        cycle();
        flush = 1;
        cycle();
        flush = 0; req_valid_in = 0; data_ok = 1;
        #1;
        checks++;
        if (outstanding !== CW'(2) || icache_valid_out !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL flush_state got out=%0d vo=%0b busy=%0b required out=2 vo=0 busy=1",
                     outstanding, icache_valid_out, busy);
        end
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if (ins_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_squash k=%0d got iv=%0b required iv=0", k, ins_valid);
            end
            cycle();
        end
        data_ok = 0; req_valid_in = 1; npc = 32'h1C00_0100;
        cycle();
        req_valid_in = 0;
        cycle();
        data_ok = 1;
        #1;
        checks++;
        if (ins_valid !== 1'b1) begin
            errors++;
            $display("FAIL post_flush_live got iv=%0b required iv=1", ins_valid);
        end
        cycle();
        data_ok = 0;
`ifdef ICACHE_REQ_PERF_EN
        #1;
        checks++;
        if (perf_squash_cnt - sq0 !== 32'd2 || perf_req_cnt - rq0 !== 32'd2) begin
            errors++;
            $display("FAIL perf_flush got sq_delta=%0d req_delta=%0d required 2 2",
                     perf_squash_cnt - sq0, perf_req_cnt - rq0);
        end
`else
        if (sq0 + rq0 == 32'hFFFF_FFFF) $display("note: counter wrap");
`endif
    endtask

    task automatic test_flush_accept_data();
        do_reset();
        npc = 32'h0000_1000; req_valid_in = 1; addr_ok = 1;
        cycle();
        cycle();
        flush = 1; data_ok = 1;
        #1;
        checks++;
        if (ins_valid !== 1'b1 || icache_valid_out !== 1'b1) begin
            errors++;
            $display("FAIL fad_same_cycle got iv=%0b vo=%0b required iv=1 vo=1", ins_valid, icache_valid_out);
        end
        cycle();
        flush = 0; req_valid_in = 0;
        #1;
        checks++;
        if (outstanding !== CW'(1) || ins_valid !== 1'b0 || icache_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL fad_discard got out=%0d iv=%0b vo=%0b required out=1 iv=0 vo=0",
                     outstanding, ins_valid, icache_valid_out);
        end
        cycle();
        data_ok = 0;
        #1;
        checks++;
        if (outstanding !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL fad_drain got out=%0d busy=%0b required out=0 busy=0", outstanding, busy);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst          = ($urandom % 128) == 0;
            stall        = ($urandom % 4) == 0;
            flush        = ($urandom % 16) == 0;
            npc          = $urandom;
            req_valid_in = ($urandom % 4) != 0;
            addr_ok      = ($urandom % 3) != 0;
            data_ok      = ($urandom % 3) == 0;
            #1;
            checks++;
            if (icache_valid_out !== exp_vo() || ins_valid !== exp_iv()
                || outstanding !== CW'(m_q.size()) || busy !== (m_req || m_q.size() != 0)
                || {icache_tag, icache_index, icache_offset} !== m_addr) begin
                errors++;
                $display("FAIL rnd cyc=%0d got vo=%0b iv=%0b out=%0d busy=%0b addr=%h required vo=%0b iv=%0b out=%0d busy=%0b addr=%h",
                         c, icache_valid_out, ins_valid, outstanding, busy, {icache_tag, icache_index, icache_offset},
                         exp_vo(), exp_iv(), m_q.size(), (m_req || m_q.size() != 0), m_addr);
            end
            cycle();
        end
`ifdef ICACHE_REQ_PERF_EN
        #1;
        checks++;
        if (perf_req_cnt !== m_perf_req || perf_squash_cnt !== m_perf_sq) begin
            errors++;
            $display("FAIL rnd_perf got req=%0d sq=%0d required req=%0d sq=%0d",
                     perf_req_cnt, perf_squash_cnt, m_perf_req, m_perf_sq);
        end
`endif
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        test_reset();
        test_first_fetch();
        test_hold_and_max_out();
        test_flush_discard();
        test_flush_accept_data();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
